// File: rtl/pulse_cdc_pkg.sv
// Shared types and parameter limits for the pulse_cdc scheduler and its round-robin picker.
package pulse_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int GAP_MIN = 1;

  function automatic bit params_ok(input int n, input int gap);
    return (n >= 2) && (gap >= GAP_MIN);
  endfunction

endpackage

// File: rtl/pulse_cdc_rr_pick.sv
// Round-robin winner select over a request vector, starting after ptr; purely combinational (0 cycles).
// No backpressure: the caller decides whether to act on vld/winner.
module pulse_cdc_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    nz,
  input  logic [ID_W-1:0] ptr,
  output logic            vld,
  output logic [ID_W-1:0] winner
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic         found;

  // Masked pass covers indices above ptr; the unmasked pass wraps around.
  always_comb begin
    mask   = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (ID_W'(i) > ptr);
    end
    masked = nz & mask;
    vld    = |nz;
    for (int i = 0; i < N; i++) begin
      if (masked[i] && !found) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (nz[i] && !found) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_cdc_sched.sv
// Shares one pulse_cdc launch among N requesters; request-to-pulse latency 1 cycle when idle, launches >= GAP+1 apart.
// Requests never stall: they accumulate in saturating counters, overflow is flagged stickily.
module pulse_cdc_sched
  import pulse_cdc_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CNT_W = 2,
  parameter  int GAP   = 8,
  localparam int ID_W  = $clog2(N)
) (
  input  logic            i_aclk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req_pulse,
  input  logic            i_enable,
  input  logic [N-1:0]    i_ovf_clr,
  output logic            o_pulse_aclk,
  output logic [ID_W-1:0] o_grant_id,
  output logic [N-1:0]    o_overflow,
  output logic            o_busy
);

  localparam int              TMR_W   = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!params_ok(N, GAP)) begin : g_bad_params
    $error("pulse_cdc_sched: requires N >= 2 and GAP >= GAP_MIN");
  end

  state_t                    state_q, state_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [N-1:0][CNT_W-1:0]   cnt_q;
  logic [N-1:0]              nz;
  logic [N-1:0]              dec;
  logic [N-1:0]              ovf_set;
  logic [ID_W-1:0]           ptr_q;
  logic                      pick_vld;
  logic [ID_W-1:0]           pick_id;
  logic                      fire;
  logic                      pulse_q;
  logic [ID_W-1:0]           grant_q;
  logic [N-1:0]              ovf_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      nz[i]      = |cnt_q[i];
      dec[i]     = fire && (pick_id == ID_W'(i));
      ovf_set[i] = i_req_pulse[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  pulse_cdc_rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .nz     (nz),
    .ptr    (ptr_q),
    .vld    (pick_vld),
    .winner (pick_id)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && pick_vld) begin
          fire    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = HOLDOFF;
        timer_d = TMR_W'(GAP);
      end
      HOLDOFF: begin
        // Last holdoff cycle may chain straight into the next launch.
        if (timer_q == TMR_W'(1)) begin
          if (i_enable && pick_vld) begin
            fire    = 1'b1;
            state_d = LAUNCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      grant_q <= '0;
      ptr_q   <= ID_W'(N - 1);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= fire;
      if (fire) begin
        grant_q <= pick_id;
        ptr_q   <= pick_id;
      end
    end
  end

  // Simultaneous increment and decrement cancel out.
  always_ff @(posedge i_aclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_req_pulse[i] && !dec[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (!i_req_pulse[i] && dec[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
      ovf_q <= ovf_set | (ovf_q & ~i_ovf_clr);
    end
  end

  assign o_pulse_aclk = pulse_q;
  assign o_grant_id   = grant_q;
  assign o_overflow   = ovf_q;
  assign o_busy       = (state_q != IDLE) || (|nz);

endmodule

// File: tb/tb_pulse_cdc_sched.sv
// Directed scenarios plus randomized traffic against a behavioural launch-spacing model.
module tb_pulse_cdc_sched;

  localparam int N    = 4;
  localparam int GAP  = 8;
  localparam int MAXC = 3;

  logic         i_aclk      = 1'b0;
  logic         i_rst_n     = 1'b0;
  logic [N-1:0] i_req_pulse = '0;
  logic         i_enable    = 1'b0;
  logic [N-1:0] i_ovf_clr   = '0;
  logic         o_pulse_aclk;
  logic [1:0]   o_grant_id;
  logic [N-1:0] o_overflow;
  logic         o_busy;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 i_aclk = ~i_aclk;

  pulse_cdc_sched #(.N(N), .CNT_W(2), .GAP(GAP)) dut (
    .i_aclk       (i_aclk),
    .i_rst_n      (i_rst_n),
    .i_req_pulse  (i_req_pulse),
    .i_enable     (i_enable),
    .i_ovf_clr    (i_ovf_clr),
    .o_pulse_aclk (o_pulse_aclk),
    .o_grant_id   (o_grant_id),
    .o_overflow   (o_overflow),
    .o_busy       (o_busy)
  );

  // Reference: a pick is allowed once GAP+1 edges have passed since the previous pick.
  int           m_cnt [N];
  int           m_ptr;
  int           m_edge;
  int           m_last;
  logic         m_pulse;
  logic [1:0]   m_gid;
  logic [N-1:0] m_ovf;
  logic         m_busy;

  always @(posedge i_aclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ptr   = N - 1;
      m_edge  = 0;
      m_last  = -1000;
      m_pulse = 1'b0;
      m_gid   = 2'd0;
      m_ovf   = '0;
      m_busy  = 1'b0;
    end else begin
      int w;
      bit any;
      int v;
      m_edge++;
      any = 0;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) any = 1;
      w = -1;
      if (i_enable && any && (m_edge - m_last) >= GAP + 1) begin
        for (int j = 1; j <= N; j++) begin
          if (w < 0 && m_cnt[(m_ptr + j) % N] != 0) w = (m_ptr + j) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        v = m_cnt[i] + int'(i_req_pulse[i]) - ((w == i) ? 1 : 0);
        if (v > MAXC) begin
          v = MAXC;
          m_ovf[i] = 1'b1;
        end else if (i_ovf_clr[i]) begin
          m_ovf[i] = 1'b0;
        end
        m_cnt[i] = v;
      end
      m_pulse = (w >= 0);
      if (w >= 0) begin
        m_gid  = 2'(w);
        m_ptr  = w;
        m_last = m_edge;
      end
      any = 0;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) any = 1;
      m_busy = ((m_edge - m_last) <= GAP) || any;
    end
  end

  task automatic tick();
    @(posedge i_aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (o_pulse_aclk !== 1'b0) $display("FAIL reset_pulse got %b want 0", o_pulse_aclk); else n_pass++;
    n_checks++; if (o_grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", o_grant_id); else n_pass++;
    n_checks++; if (o_overflow !== 4'b0) $display("FAIL reset_ovf got %b want 0000", o_overflow); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else n_pass++;
    i_rst_n = 1'b1;
    i_enable = 1'b1;
    tick();
    n_checks++; if (o_busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_three();
    i_req_pulse = 4'b1011;
    for (int c = 0; c <= 30; c++) begin
      logic       exp_p;
      logic [1:0] exp_g;
      tick();
      i_req_pulse = '0;
      exp_p = (c == 1) || (c == 10) || (c == 19);
      exp_g = (c < 10) ? 2'd0 : (c < 19) ? 2'd1 : 2'd3;
      n_checks++; if (o_pulse_aclk !== exp_p) $display("FAIL three_pulse c=%0d got %b want %b", c, o_pulse_aclk, exp_p); else n_pass++;
      if (c >= 1) begin
        n_checks++; if (o_grant_id !== exp_g) $display("FAIL three_grant c=%0d got %0d want %0d", c, o_grant_id, exp_g); else n_pass++;
      end
      n_checks++; if (o_busy !== (c < 28)) $display("FAIL three_busy c=%0d got %b want %b", c, o_busy, (c < 28)); else n_pass++;
    end
  endtask

  task automatic test_single();
    i_req_pulse = 4'b0100;
    for (int c = 0; c <= 12; c++) begin
      tick();
      i_req_pulse = '0;
      n_checks++; if (o_pulse_aclk !== (c == 1)) $display("FAIL single_pulse c=%0d got %b want %b", c, o_pulse_aclk, (c == 1)); else n_pass++;
      if (c >= 1) begin
        n_checks++; if (o_grant_id !== 2'd2) $display("FAIL single_grant c=%0d got %0d want 2", c, o_grant_id); else n_pass++;
      end
      n_checks++; if (o_busy !== (c < 10)) $display("FAIL single_busy c=%0d got %b want %b", c, o_busy, (c < 10)); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    int launches = 0;
    for (int c = 0; c <= 40; c++) begin
      i_req_pulse = (c <= 4) ? 4'b0010 : 4'b0000;
      tick();
      if (o_pulse_aclk === 1'b1 && o_grant_id === 2'd1) launches++;
      if (c == 3) begin
        n_checks++; if (o_overflow !== 4'b0000) $display("FAIL ovf_early got %b want 0000", o_overflow); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (o_overflow !== 4'b0010) $display("FAIL ovf_set got %b want 0010", o_overflow); else n_pass++;
      end
    end
    i_req_pulse = '0;
    n_checks++; if (launches != 4) $display("FAIL ovf_launches got %0d want 4", launches); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL ovf_drained_busy got %b want 0", o_busy); else n_pass++;
    i_ovf_clr = 4'b0010;
    tick();
    i_ovf_clr = '0;
    n_checks++; if (o_overflow !== 4'b0000) $display("FAIL ovf_clear got %b want 0000", o_overflow); else n_pass++;
  endtask

  task automatic test_enable();
    i_enable = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      i_req_pulse = (c <= 1) ? 4'b0001 : 4'b0000;
      tick();
      n_checks++; if (o_pulse_aclk !== 1'b0) $display("FAIL dis_pulse c=%0d got %b want 0", c, o_pulse_aclk); else n_pass++;
      n_checks++; if (o_busy !== 1'b1) $display("FAIL dis_busy c=%0d got %b want 1", c, o_busy); else n_pass++;
    end
    i_req_pulse = '0;
    i_enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_checks++; if (o_pulse_aclk !== (c == 1 || c == 10)) $display("FAIL en_pulse c=%0d got %b want %b", c, o_pulse_aclk, (c == 1 || c == 10)); else n_pass++;
      n_checks++; if (o_grant_id !== 2'd0) $display("FAIL en_grant c=%0d got %0d want 0", c, o_grant_id); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 4; c++) begin
      i_req_pulse = (c <= 2) ? 4'b1000 : 4'b0000;
      tick();
    end
    n_checks++; if (o_busy !== 1'b1 || o_grant_id !== 2'd3) $display("FAIL mid_pre busy=%b grant=%0d want 1/3", o_busy, o_grant_id); else n_pass++;
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_pulse_aclk !== 1'b0) $display("FAIL mid_rst_pulse got %b want 0", o_pulse_aclk); else n_pass++;
    n_checks++; if (o_grant_id !== 2'd0) $display("FAIL mid_rst_grant got %0d want 0", o_grant_id); else n_pass++;
    n_checks++; if (o_overflow !== 4'b0) $display("FAIL mid_rst_ovf got %b want 0000", o_overflow); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", o_busy); else n_pass++;
    repeat (2) tick();
    #2 i_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++; if (o_pulse_aclk !== 1'b0 || o_busy !== 1'b0) $display("FAIL mid_after c=%0d pulse=%b busy=%b want 0/0", c, o_pulse_aclk, o_busy); else n_pass++;
    end
  endtask

  task automatic test_random();
    int last_rise = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) i_req_pulse[i] = ($urandom_range(0, 5) == 0);
      i_enable  = ($urandom_range(0, 9) != 0);
      i_ovf_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      tick();
      n_checks++; if (o_pulse_aclk !== m_pulse) $display("FAIL rnd_pulse c=%0d got %b want %b", c, o_pulse_aclk, m_pulse); else n_pass++;
      n_checks++; if (o_grant_id !== m_gid) $display("FAIL rnd_grant c=%0d got %0d want %0d", c, o_grant_id, m_gid); else n_pass++;
      n_checks++; if (o_overflow !== m_ovf) $display("FAIL rnd_ovf c=%0d got %b want %b", c, o_overflow, m_ovf); else n_pass++;
      n_checks++; if (o_busy !== m_busy) $display("FAIL rnd_busy c=%0d got %b want %b", c, o_busy, m_busy); else n_pass++;
      if (o_pulse_aclk === 1'b1) begin
        if (last_rise >= 0) begin
          n_checks++; if (c - last_rise < GAP + 1) $display("FAIL rnd_spacing c=%0d got %0d want >=%0d", c, c - last_rise, GAP + 1); else n_pass++;
        end
        last_rise = c;
      end
    end
    i_req_pulse = '0;
    i_ovf_clr   = '0;
    i_enable    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_three();
    test_single();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_cdc_sched.md
Name: pulse_cdc_sched

Overview:
- Source-domain scheduler that shares one pulse_cdc channel among N event requesters, all in the aclk domain.
- Per-requester saturating pending counters ensure single-cycle request pulses are not dropped.
- A round-robin pick chooses the next requester. The block issues one single-cycle launch pulse to pulse_cdc, then enforces a holdoff so the synchroniser is never re-triggered before the previous pulse has crossed.
- o_grant_id is a quasi-static sideband that the bclk domain samples on o_pulse_bclk.

Parameters:
- N, 4, number of requesters (>=2).
- CNT_W, 2, pending counter width; saturates at 2**CNT_W-1.
- GAP, 8, holdoff cycles after each launch (>=1). Sized to the pulse_cdc crossing time in aclk cycles.
- ID_W, $clog2(N), grant id width (derived; do not override).

Ports:
- i_aclk  in  1  clock. All logic is in this domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_pulse  in  N  single-cycle event requests, one bit per requester.
- i_enable  in  1  launch enable. Counters keep accumulating while low.
- i_ovf_clr  in  N  clears the sticky overflow flags.
- o_pulse_aclk  out  1  launch pulse to pulse_cdc i_pulse_aclk. One cycle wide.
- o_grant_id  out  ID_W  requester served by the latest launch. Held until the next launch.
- o_overflow  out  N  sticky; a request arrived while that counter was saturated.
- o_busy  out  1  high when state!=IDLE or any counter is nonzero.

Behaviour:
- Reset state (asynchronous): all counters 0, o_pulse_aclk 0, o_grant_id 0, o_overflow 0, state IDLE, RR pointer N-1 (so the first search starts at 0). Reset asserted mid-operation discards all pending counts immediately; no pulse is issued after release unless a new request arrives.
- Counter update each edge: cnt += req (saturating) and cnt -= launch_dec.
  - Increment and decrement in the same edge leave cnt unchanged.
  - Increment at max leaves cnt at max and sets o_overflow[i].
  - Set has priority over i_ovf_clr[i] in the same edge.
- FSM states: IDLE, LAUNCH, HOLDOFF.
- IDLE: if i_enable and any cnt!=0, the edge picks winner w and moves to LAUNCH.
  - w is the first nonzero counter searching from ptr+1 modulo N.
  - The same edge decrements cnt[w], loads o_grant_id=w and ptr=w.
  - The pick uses the registered counts; a request sampled on the same edge is not visible until the next edge.
- LAUNCH: o_pulse_aclk=1 for exactly this one cycle (registered). The next edge moves to HOLDOFF and loads timer=GAP.
- HOLDOFF: o_pulse_aclk=0; the timer decrements each edge. On the edge where timer==1:
  - If i_enable and any cnt!=0, pick and go directly to LAUNCH.
  - Otherwise go to IDLE.
- Latency: request sampled at edge k with the FSM idle and enabled gives o_pulse_aclk high from edge k+1 to edge k+2.
- Under continuous load, launches are spaced exactly GAP+1 cycles apart (rising edge to rising edge). The spacing is never less.
- i_enable low: a launch or holdoff already in progress completes normally; no new pick is made.
- o_grant_id changes only on edges entering LAUNCH. It is therefore stable for at least GAP+1 cycles around each pulse.

Decomposition:
- Package pulse_cdc_pkg holds:
  - the state enum (IDLE, LAUNCH, HOLDOFF);
  - the GAP_MIN=1 constant;
  - an elaboration check for GAP>=GAP_MIN and N>=2.
- Sub-module pulse_cdc_rr_pick (combinational): takes the nonzero-count vector and ptr, and returns valid plus winner index. It uses the masked/unmasked double-priority form.
- Counters, FSM and timer live in pulse_cdc_sched.

Test Plan:
- Use N=4, CNT_W=2, GAP=8 for all scenarios.
- Single request on ch2 sampled at edge 10 -> o_pulse_aclk high for exactly the cycle edge 11 to 12, o_grant_id=2, o_busy low again after edge 20.
- ch0, ch1 and ch3 requested on the same edge 10 -> launches at edges 11, 20 and 29 with o_grant_id 0, 1, 3; no pulse in between; o_grant_id never changes during holdoff.
- ch1 requested on 5 consecutive edges 0-4 -> o_overflow[1]=1 after edge 4; exactly 4 launches for ch1; then i_ovf_clr[1] clears the flag.
- i_enable=0 with ch0 requested twice -> no pulse and o_busy=1; i_enable=1 sampled at edge e -> launches at e+1 and e+10.
- i_rst_n dropped mid-HOLDOFF with cnt[3]=2 -> all outputs 0 immediately; after release, no pulse for 20 cycles.
- End-to-end with pulse_cdc, aclk 12 ns and bclk 20 ns: 3 simultaneous requests produce 3 distinct one-bclk-wide o_pulse_bclk pulses, each low on the following bclk edge. o_grant_id sampled on each pulse reads 0, 1, 3.
